midi_msg_parser: RTL

//  Byte-level MIDI channel-message parser sitting between the MIDI UART receiver and midi_controllers/voice allocation.

---
 rtl/midi_msg_parser.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/midi_msg_parser.sv
// ---------------------------------------------------------------------------
// midi_msg_parser
//
// Byte-level MIDI channel-message parser. Sits between the MIDI UART receiver
// and the controller / voice-allocation logic. Tracks status and running
// status, filters one channel (or all channels when OMNI=1), and emits note,
// controller, program, aftertouch and pitch-bend events as fixed-width
// strobes with a held ictrl/ictrl_data payload.
//
// Ports
//   CLOCK_25      in   system clock, all logic on posedge
//   reset_data_N  in   asynchronous active-low reset
//   byte_in[7:0]  in   received MIDI byte, qualified by byte_valid
//   byte_valid    in   one-clock strobe per received byte (never back-pressured)
//   ictrl[7:0]    out  CC number | pitch LSB | program number | key
//   ictrl_data    out  CC value | pitch MSB | velocity | 0 for 1-byte messages
//   ctrl_cmd      out  control-change strobe (Bn)
//   pitch_cmd     out  pitch-bend strobe (En)
//   prg_cmd       out  program-change strobe (Cn)
//   at_cmd        out  channel-aftertouch strobe (Dn)
//   note_on       out  note-on strobe (9n, velocity > 0)
//   note_off      out  note-off strobe (8n, or 9n with velocity 0)
//   dbg_state_o   out  current parser state (IDLE/WAIT1/WAIT2/SYSEX)
//
// Handshake: byte_valid is a single-cycle qualifier with no ready; every byte
// presented with byte_valid=1 is consumed on that clock edge. Event strobes
// rise one clock after the final data byte and stay high CMD_PULSE clocks.
// ---------------------------------------------------------------------------
module midi_msg_parser #(
    parameter int MIDI_CH   = 0,
    parameter bit OMNI      = 1'b0,
    parameter int CMD_PULSE = 2
) (
    input  logic       CLOCK_25,
    input  logic       reset_data_N,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] ictrl,
    output logic [7:0] ictrl_data,
    output logic       ctrl_cmd,
    output logic       pitch_cmd,
    output logic       prg_cmd,
    output logic       at_cmd,
    output logic       note_on,
    output logic       note_off,
    output logic [1:0] dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT1 = 2'd1;
    localparam logic [1:0] S_WAIT2 = 2'd2;
    localparam logic [1:0] S_SYSEX = 2'd3;

    // One-hot strobe selector bit positions
    localparam int SEL_CTRL  = 0;
    localparam int SEL_PITCH = 1;
    localparam int SEL_PRG   = 2;
    localparam int SEL_AT    = 3;
    localparam int SEL_NON   = 4;
    localparam int SEL_NOFF  = 5;

    logic [1:0] state_q, state_d;
    logic [7:0] status_q, status_d;     // running status, 0 = none
    logic [6:0] d1_q, d1_d;
    logic [7:0] ictrl_q, ictrl_d;
    logic [7:0] ictrl_data_q, ictrl_data_d;
    logic [5:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;

    logic       is_realtime;
    logic       one_byte;
    logic       match;
    logic       complete;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;
    logic [3:0] hi_nib;

    assign hi_nib      = status_q[7:4];
    assign is_realtime = (byte_in >= 8'hF8);
    assign one_byte    = (hi_nib == 4'hC) || (hi_nib == 4'hD);
    assign match       = OMNI || (status_q[3:0] == MIDI_CH[3:0]);

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        d1_d         = d1_q;
        ictrl_d      = ictrl_q;
        ictrl_data_d = ictrl_data_q;
        sel_d        = sel_q;
        cnt_d        = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
        complete     = 1'b0;
        msg_d1       = 7'd0;
        msg_d2       = 7'd0;

        if (byte_valid && !is_realtime) begin
            if (byte_in[7]) begin
                if (byte_in <= 8'hEF) begin
                    status_d = byte_in;
                    d1_d     = 7'd0;
                    state_d  = S_WAIT1;
                end else if (byte_in == 8'hF0) begin
                    status_d = 8'h00;
                    state_d  = S_SYSEX;
                end else begin
                    // F1..F7: system common; their data is dropped in IDLE
                    status_d = 8'h00;
                    state_d  = S_IDLE;
                end
            end else begin
                case (state_q)
                    S_WAIT1: begin
                        d1_d = byte_in[6:0];
                        if (one_byte) begin
                            complete = 1'b1;
                            msg_d1   = byte_in[6:0];
                        end else begin
                            state_d = S_WAIT2;
                        end
                    end
                    S_WAIT2: begin
                        complete = 1'b1;
                        msg_d1   = d1_q;
                        msg_d2   = byte_in[6:0];
                        state_d  = S_WAIT1;   // running status reused
                    end
                    default: ;                // IDLE / SYSEX discard data
                endcase
            end
        end

        // Poly aftertouch (An) completes silently and leaves outputs alone.
        if (complete && match && (hi_nib != 4'hA)) begin
            ictrl_d      = {1'b0, msg_d1};
            ictrl_data_d = {1'b0, msg_d2};
            cnt_d        = CMD_PULSE[3:0];
            sel_d        = 6'd0;
            case (hi_nib)
                4'h8:    sel_d[SEL_NOFF]  = 1'b1;
                4'h9:    begin
                    if (msg_d2 == 7'd0) sel_d[SEL_NOFF] = 1'b1;
                    else                sel_d[SEL_NON]  = 1'b1;
                end
                4'hB:    sel_d[SEL_CTRL]  = 1'b1;
                4'hC:    sel_d[SEL_PRG]   = 1'b1;
                4'hD:    sel_d[SEL_AT]    = 1'b1;
                4'hE:    sel_d[SEL_PITCH] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_data_N) begin
        if (!reset_data_N) begin
            state_q      <= S_IDLE;
            status_q     <= 8'h00;
            d1_q         <= 7'd0;
            ictrl_q      <= 8'h00;
            ictrl_data_q <= 8'h00;
            sel_q        <= 6'd0;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            d1_q         <= d1_d;
            ictrl_q      <= ictrl_d;
            ictrl_data_q <= ictrl_data_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
        end
    end

    // The selector persists after the pulse; the counter gates it so only a
    // live pulse reaches the strobe outputs.
    logic pulse_active;
    assign pulse_active = (cnt_q != 4'd0);

    assign ctrl_cmd    = sel_q[SEL_CTRL]  & pulse_active;
    assign pitch_cmd   = sel_q[SEL_PITCH] & pulse_active;
    assign prg_cmd     = sel_q[SEL_PRG]   & pulse_active;
    assign at_cmd      = sel_q[SEL_AT]    & pulse_active;
    assign note_on     = sel_q[SEL_NON]   & pulse_active;
    assign note_off    = sel_q[SEL_NOFF]  & pulse_active;
    assign ictrl       = ictrl_q;
    assign ictrl_data  = ictrl_data_q;
    assign dbg_state_o = state_q;

endmodule
